// File: rtl/costas_pkg.sv
// Shared definitions for the Costas-loop NCO: default widths, quadrant
// encoding and the quarter-wave sine table generator.
package costas_pkg;

    localparam int PHASE_W_DFLT = 32;
    localparam int LUT_AW_DFLT  = 8;
    localparam int OUT_W_DFLT   = 16;

    localparam real PI = 3.14159265358979323846;

    // Quadrant taken from the two MSBs of the phase word.
    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quad_e;

    // Quarter-wave entry i, sampled at the bin centre so no entry is zero
    // and the full-scale value stays one below the negative limit.
    function automatic int lut_value(input int idx, input int lut_aw, input int out_w);
        real amp;
        real ang;
        amp = real'((1 << (out_w - 1)) - 1);
        ang = (PI / 2.0) * (real'(idx) + 0.5) / real'(1 << lut_aw);
        return $rtoi(amp * $sin(ang) + 0.5);
    endfunction

endpackage

// File: rtl/costas_nco_qlut.sv
// Registered quarter-wave sine ROM with two independent read ports and a
// one-cycle read latency. Entries are unsigned magnitudes (OUT_W-1 bits).
module costas_nco_qlut
    import costas_pkg::*;
#(
    parameter int LUT_AW = LUT_AW_DFLT,
    parameter int OUT_W  = OUT_W_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LUT_AW-1:0] addr_a_i,
    input  logic [LUT_AW-1:0] addr_b_i,
    output logic [OUT_W-2:0]  data_a_o,
    output logic [OUT_W-2:0]  data_b_o
);

    localparam int DEPTH = 1 << LUT_AW;
    localparam int MAG_W = OUT_W - 1;

    logic [MAG_W-1:0] rom [DEPTH];
    logic [MAG_W-1:0] data_a_q;
    logic [MAG_W-1:0] data_b_q;

    // Table contents are elaboration-time constants.
    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam int V = lut_value(i, LUT_AW, OUT_W);
        assign rom[i] = MAG_W'(V);
    end

    // Registered read of both ports.
    // NOTE: the table itself is constant and never reset; only the read
    // registers are, so a reset clears in-flight samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_a_q <= '0;
            data_b_q <= '0;
        end else begin
            data_a_q <= rom[addr_a_i];
            data_b_q <= rom[addr_b_i];
        end
    end

    assign data_a_o = data_a_q;
    assign data_b_o = data_b_q;

endmodule

// File: rtl/costas_nco.sv
// Costas-loop NCO: phase accumulator driven by a centre frequency plus the
// loop-filter correction, followed by a 3-stage quarter-wave sin/cos pipeline.
// Optional build macro COSTAS_NCO_PHASE_OFST_EN adds a phase_ofst input that
// rotates the decoded phase without touching the accumulator.
module costas_nco
    import costas_pkg::*;
#(
    parameter int                 PHASE_W     = PHASE_W_DFLT,
    parameter int                 LUT_AW      = LUT_AW_DFLT,
    parameter int                 OUT_W       = OUT_W_DFLT,
    parameter logic [PHASE_W-1:0] CENTER_FREQ = 32'h0800_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      phase_clr,
    input  logic signed [PHASE_W-1:0] frequency_df,
`ifdef COSTAS_NCO_PHASE_OFST_EN
    input  logic        [PHASE_W-1:0] phase_ofst,
`endif
    output logic        [PHASE_W-1:0] phase,
    output logic signed [OUT_W-1:0]   sin_out,
    output logic signed [OUT_W-1:0]   cos_out,
    output logic                      out_valid
);

    localparam int FRAC_W = PHASE_W - 2 - LUT_AW;

    logic [PHASE_W-1:0]      phase_d;
    logic [PHASE_W-1:0]      phase_q;
    logic [PHASE_W-1:0]      dec_phase;
    logic [FRAC_W-1:0]       unused_frac;

    quad_e                   quad_s1_q;
    logic [LUT_AW-1:0]       idx_s1_q;
    quad_e                   quad_s2_q;
    logic [OUT_W-2:0]        mag_a;
    logic [OUT_W-2:0]        mag_b;

    logic                    vld_s0_q;
    logic                    vld_s1_q;
    logic                    vld_s2_q;

    logic signed [OUT_W-1:0] pos_a;
    logic signed [OUT_W-1:0] pos_b;
    logic signed [OUT_W-1:0] sin_d;
    logic signed [OUT_W-1:0] cos_d;
    logic signed [OUT_W-1:0] sin_q;
    logic signed [OUT_W-1:0] cos_q;
    logic                    out_vld_q;

    // Next phase: clear beats enable; wraps modulo 2^PHASE_W.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        phase_d = phase_q;
        if (phase_clr) begin
            phase_d = '0;
        end else if (en) begin
            phase_d = phase_q + CENTER_FREQ + $unsigned(frequency_df);
        end
    end

    // Phase accumulator and sample-launch flag, aligned with each other.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= '0;
            vld_s0_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            vld_s0_q <= en;
        end
    end

`ifdef COSTAS_NCO_PHASE_OFST_EN
    assign dec_phase = phase_q + phase_ofst;
`else
    assign dec_phase = phase_q;
`endif

    // Phase bits below the table index are truncated by design.
    assign unused_frac = dec_phase[FRAC_W-1:0];

    // Stage 1: quadrant and table index decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            quad_s1_q <= QUAD_0;
            idx_s1_q  <= '0;
            vld_s1_q  <= 1'b0;
        end else begin
            quad_s1_q <= quad_e'(dec_phase[PHASE_W-1 -: 2]);
            idx_s1_q  <= dec_phase[PHASE_W-3 -: LUT_AW];
            vld_s1_q  <= vld_s0_q;
        end
    end

    // Stage 2: table reads for idx (port a) and its mirror ~idx (port b).
    costas_nco_qlut #(
        .LUT_AW (LUT_AW),
        .OUT_W  (OUT_W)
    ) u_qlut (
        .clk      (clk),
        .rst      (rst),
        .addr_a_i (idx_s1_q),
        .addr_b_i (~idx_s1_q),
        .data_a_o (mag_a),
        .data_b_o (mag_b)
    );

    // Stage 2: quadrant and valid travel alongside the table read.
    always_ff @(posedge clk) begin
        if (rst) begin
            quad_s2_q <= QUAD_0;
            vld_s2_q  <= 1'b0;
        end else begin
            quad_s2_q <= quad_s1_q;
            vld_s2_q  <= vld_s1_q;
        end
    end

    assign pos_a = $signed({1'b0, mag_a});
    assign pos_b = $signed({1'b0, mag_b});

    // Stage 3 next-state: mirror and sign per quadrant; hold when idle.
    always_comb begin
        sin_d = sin_q;
        cos_d = cos_q;
        if (vld_s2_q) begin
            unique case (quad_s2_q)
                QUAD_0: begin sin_d =  pos_a; cos_d =  pos_b; end
                QUAD_1: begin sin_d =  pos_b; cos_d = -pos_a; end
                QUAD_2: begin sin_d = -pos_a; cos_d = -pos_b; end
                QUAD_3: begin sin_d = -pos_b; cos_d =  pos_a; end
                default: begin sin_d = sin_q; cos_d = cos_q; end
            endcase
        end
    end

    // Stage 3: output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sin_q     <= '0;
            cos_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            sin_q     <= sin_d;
            cos_q     <= cos_d;
            out_vld_q <= vld_s2_q;
        end
    end

    assign phase     = phase_q;
    assign sin_out   = sin_q;
    assign cos_out   = cos_q;
    assign out_valid = out_vld_q;

endmodule

// File: tb/tb_costas_nco.sv
// Scoreboard bench for costas_nco (default CENTER_FREQ = 2^27). Stimulus
// pushes hand-computed samples tagged with the cycle they must emerge on;
// a negedge monitor pops and compares, and checks hold behaviour when idle.
// Define COSTAS_NCO_PHASE_OFST_EN to also exercise the phase offset port.
module tb_costas_nco;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               phase_clr;
    logic signed [31:0] frequency_df;
`ifdef COSTAS_NCO_PHASE_OFST_EN
    logic        [31:0] phase_ofst;
`endif
    logic        [31:0] phase;
    logic signed [15:0] sin_out;
    logic signed [15:0] cos_out;
    logic               out_valid;

    typedef struct {
        int                 due;
        logic signed [15:0] s;
        logic signed [15:0] c;
    } sb_t;

    sb_t                sb_q[$];
    sb_t                item;
    int                 cyc = 0;
    int                 n_checks = 0;
    int                 n_pass = 0;
    logic               mon_en = 1'b0;
    logic               exp_v;
    logic signed [15:0] last_sin = '0;
    logic signed [15:0] last_cos = '0;

    // Step sizes with CENTER_FREQ = 2^27.
    localparam logic [31:0] DF_QUARTER = 32'h3800_0000; // total step 2^30
    localparam logic [31:0] DF_MINUS1  = 32'hF7FF_FFFF; // total step -1
    localparam logic [31:0] DF_ZERO    = 32'hF800_0000; // total step 0

    costas_nco dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .phase_clr    (phase_clr),
        .frequency_df (frequency_df),
`ifdef COSTAS_NCO_PHASE_OFST_EN
        .phase_ofst   (phase_ofst),
`endif
        .phase        (phase),
        .sin_out      (sin_out),
        .cos_out      (cos_out),
        .out_valid    (out_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One clock of stimulus; exp_s/exp_c are the sample for the new phase.
    task automatic step(input logic r, input logic e, input logic c,
                        input logic [31:0] df, input logic [31:0] exp_ph,
                        input logic signed [15:0] exp_s,
                        input logic signed [15:0] exp_c);
        rst          = r;
        en           = e;
        phase_clr    = c;
        frequency_df = df;
        @(posedge clk);
        #1;
        if (r) begin
            sb_q.delete();
            last_sin = '0;
            last_cos = '0;
            check("rst_out_valid", out_valid, 0);
            check("rst_sin", sin_out, 0);
            check("rst_cos", cos_out, 0);
        end else if (e) begin
            sb_q.push_back('{due: cyc + 3, s: exp_s, c: exp_c});
        end
        check("phase", phase, exp_ph);
    endtask

    // Monitor: valid must appear exactly when a sample is due.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_v = (sb_q.size() != 0) && (sb_q[0].due == cyc);
            check("out_valid", out_valid, exp_v);
            if (exp_v) begin
                item = sb_q.pop_front();
                check("sin", sin_out, item.s);
                check("cos", cos_out, item.c);
                last_sin = item.s;
                last_cos = item.c;
            end else if (!out_valid) begin
                check("sin_hold", sin_out, last_sin);
                check("cos_hold", cos_out, last_cos);
            end
        end
    end

    initial begin
`ifdef COSTAS_NCO_PHASE_OFST_EN
        phase_ofst = '0;
`endif
        // Reset held with enable and a correction present.
        step(1, 1, 0, 32'd1000, 32'h0, 0, 0);
        mon_en = 1'b1;
        step(1, 1, 0, 32'd1000, 32'h0, 0, 0);
        step(1, 1, 0, 32'd1000, 32'h0, 0, 0);

        // Quarter-rate tone.
        step(0, 1, 0, DF_QUARTER, 32'h4000_0000,  32767,   -101);
        step(0, 1, 0, DF_QUARTER, 32'h8000_0000,   -101, -32767);
        step(0, 1, 0, DF_QUARTER, 32'hC000_0000, -32767,    101);
        step(0, 1, 0, DF_QUARTER, 32'h0000_0000,    101,  32767);
        step(0, 1, 0, DF_QUARTER, 32'h4000_0000,  32767,   -101);

        // Clear beats enable; the launched sample is for phase 0.
        step(0, 1, 1, DF_QUARTER, 32'h0000_0000,    101,  32767);

        // Enable gating 1,0,0,1.
        step(0, 1, 0, DF_QUARTER, 32'h4000_0000,  32767,   -101);
        step(0, 0, 0, DF_QUARTER, 32'h4000_0000,      0,      0);
        step(0, 0, 0, DF_QUARTER, 32'h4000_0000,      0,      0);
        step(0, 1, 0, DF_QUARTER, 32'h8000_0000,   -101, -32767);

        // Clear-only cycle launches nothing.
        step(0, 0, 1, DF_QUARTER, 32'h0000_0000,      0,      0);

        // Negative step wraps below zero: q3, idx 255.
        step(0, 1, 0, DF_MINUS1,  32'hFFFF_FFFF,   -101,  32767);
        step(0, 1, 0, DF_MINUS1,  32'hFFFF_FFFE,   -101,  32767);

        // Two samples in flight, then reset together with clear.
        step(0, 1, 1, DF_QUARTER, 32'h0000_0000,    101,  32767);
        step(0, 1, 0, DF_QUARTER, 32'h4000_0000,  32767,   -101);
        step(1, 1, 1, DF_QUARTER, 32'h0000_0000,      0,      0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 32'h0, 32'h0, 0, 0);

`ifdef COSTAS_NCO_PHASE_OFST_EN
        // Half-turn offset rotates the sample, not the accumulator.
        phase_ofst = 32'h8000_0000;
        step(0, 1, 0, DF_ZERO, 32'h0000_0000, -101, -32767);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h0, 32'h0, 0, 0);
        phase_ofst = '0;
`endif

        // Drain and confirm every expected sample emerged.
        for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h0, 32'h0, 0, 0);
        mon_en = 1'b0;
        check("scoreboard_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/costas_nco.md
Name: costas_nco

Overview:
- Numerically controlled oscillator that closes the Costas carrier-recovery loop.
- Consumes the signed frequency correction `frequency_df` driven by the loop filter and adds it to a fixed centre frequency word.
- Integrates the result into a phase accumulator.
- Emits quadrature sin/cos samples from a pipelined quarter-wave LUT; these samples feed the I/Q mixers ahead of the phase detector.

Parameters:
- PHASE_W, 32, phase accumulator width; `frequency_df` is PHASE_W wide.
- LUT_AW, 8, quarter-wave LUT address bits (2^LUT_AW entries).
- OUT_W, 16, signed sin/cos output width.
- CENTER_FREQ, 32'h0800_0000, unsigned nominal phase increment per enabled cycle.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  sample enable; advances phase and launches one output sample.
- phase_clr  input  1  synchronous phase accumulator clear.
- frequency_df  input  PHASE_W (signed)  loop filter frequency correction.
- phase  output  PHASE_W  current phase accumulator value.
- sin_out  output  OUT_W (signed)  sine sample.
- cos_out  output  OUT_W (signed)  cosine sample.
- out_valid  output  1  sin_out/cos_out hold a new sample.

Behaviour:
- Reset (rst=1 at an edge):
  - phase, all pipeline registers, sin_out, cos_out and out_valid go to 0.
  - Reset dominates phase_clr and en.
  - Reset mid-operation discards in-flight samples; out_valid is 0 on the edge after reset.
- Phase accumulator update at each edge, in priority order:
  1. rst → 0
  2. phase_clr → 0 (regardless of en)
  3. en → phase + CENTER_FREQ + frequency_df, modulo 2^PHASE_W (two's-complement wrap, no saturation)
  4. otherwise hold
- Pipeline, fixed latency 3:
  - Stage 1 registers quadrant q = phase[PHASE_W-1:PHASE_W-2] and idx = phase[PHASE_W-3 -: LUT_AW], from the phase value present after edge k.
  - Stage 2 registers LUT reads for idx and ~idx, plus q.
  - Stage 3 applies sign and mirroring, then registers the outputs.
  - Outputs at edge k+3 correspond to the phase held after edge k.
  - out_valid is the en value at edge k delayed 3 edges. It is 0 for samples launched by a phase_clr-only cycle.
- LUT contents: L[i] = round((2^(OUT_W-1)-1) * sin(pi/2 * (i+0.5)/2^LUT_AW)).
  - The half-bin offset means no entry is 0, and negation never overflows.
  - With defaults: L[0]=101, L[255]=32767.
- Quadrant mapping (sin, cos):
  - q0: ( L[idx],  L[~idx])
  - q1: ( L[~idx], -L[idx])
  - q2: (-L[idx],  -L[~idx])
  - q3: (-L[~idx],  L[idx])
- Truncated phase bits below idx are ignored.
- While out_valid=0, sin_out/cos_out hold their last values.
- The pipeline advances every cycle; there is no backpressure.

Optional Feature:
- Macro COSTAS_NCO_PHASE_OFST_EN.
- When defined:
  - Adds input port `phase_ofst` [PHASE_W-1:0].
  - Stage 1 decodes q/idx from (phase + phase_ofst) mod 2^PHASE_W.
  - The `phase` output and the accumulator itself are unaffected.
  - Latency is unchanged.
- When undefined: no port exists, and decode uses phase directly.

Decomposition:
- Package costas_pkg holds:
  - PHASE_W, OUT_W, LUT_AW defaults
  - the quadrant encoding constants
  - the LUT initialisation function (real-valued sine, rounding as specified)
- One sub-module, costas_nco_qlut:
  - registered quarter-wave ROM with two read ports (idx, ~idx), 1-cycle read latency.
  - The top level owns the accumulator, decode, sign stage and valid pipeline.

Test Plan:
- Reset: hold rst=1 for 3 cycles with en=1 and frequency_df=1000 → phase=0, sin_out=0, cos_out=0, out_valid=0 throughout. After release, the first out_valid=1 appears 3 edges after the first en edge.
- Quarter-rate tone: CENTER_FREQ=2^30, frequency_df=0, en=1 → phase steps 2^30, 2^31, 3·2^30, 0. (sin, cos) repeats (101, 32767), (32767, -101), (-101, -32767), (-32767, 101), aligned with latency 3.
- Wrap and negative correction: CENTER_FREQ=0, frequency_df=-1, en=1 from phase 0 → phase=32'hFFFF_FFFF, then 32'hFFFF_FFFE. The sample for 32'hFFFF_FFFF has q3, idx=255: sin=-101, cos=32767.
- Enable gating:
  - Toggle en 1,0,0,1 → phase holds during en=0.
  - out_valid pattern 1,0,0,1 appears delayed 3 cycles.
  - sin/cos hold while out_valid=0.
- Clear priority:
  - phase_clr=1 with en=1 at phase=32'h4000_0000 → next phase=0.
  - rst=1 with phase_clr=1 → all zero.
  - rst asserted with 2 samples in flight → no out_valid pulse emerges.
- Optional (COSTAS_NCO_PHASE_OFST_EN): phase=0, phase_ofst=2^31, en=1 → sin=-101, cos=-32767, while the phase output still reads the unshifted value.
